// File: rtl/sdpram_stream_writer.sv
// Write-side front end for the simple dual-port RAM (port A).
// Turns a valid/ready word stream into sequential RAM write strobes starting at a
// programmable base and wrapping at the end of the array. Also offers a zero-sweep
// that clears a region through the RAM's port-A reset.
module sdpram_stream_writer #(
    parameter int unsigned DP = 512,
    parameter int unsigned DW = 8,
    parameter int unsigned AW = $clog2(DP)
) (
    input  logic          CLKA,
    input  logic          rstb,
    input  logic          start,
    input  logic          clear,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    output logic          ram_ce,
    output logic          ram_rst,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic [AW-1:0] wr_ptr,
    output logic [AW:0]   words,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0]   DpFull   = (AW+1)'(DP);
    localparam logic [AW-1:0] AddrLast = AW'(DP - 1);
    localparam logic [AW-1:0] AddrOne  = AW'(1);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);

    typedef enum logic [1:0] {StIdle, StFill, StClear} state_e;

    state_e        state_q;
    logic [AW-1:0] addr_q;
    logic [AW:0]   len_q;
    logic [AW:0]   cnt_q;

    logic [AW:0]   base_ext;
    logic [AW:0]   base_mod;
    logic [AW:0]   len_eff;
    logic [AW-1:0] addr_inc;
    logic [AW:0]   cnt_inc;

    // Latch-time normalisation of base/length and the shared address/count advance.
    // base_addr < 2^AW < 2*DP, so a single conditional subtract is a full modulo.
    always_comb begin
        base_ext = {1'b0, base_addr};
        base_mod = (base_ext >= DpFull) ? (base_ext - DpFull) : base_ext;
        len_eff  = ((length == '0) || (length > DpFull)) ? DpFull : length;
        addr_inc = (addr_q == AddrLast) ? '0 : (addr_q + AddrOne);
        cnt_inc  = cnt_q + CntOne;
    end

    assign s_ready = (state_q == StFill);
    assign busy    = (state_q != StIdle);

    // Control FSM; every RAM-facing output is registered so a strobe lands one cycle after
    // its beat is accepted (or its sweep step is taken).
    always_ff @(posedge CLKA) begin
        if (rstb) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            ram_ce   <= 1'b0;
            ram_rst  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
            wr_ptr   <= '0;
            words    <= '0;
            done     <= 1'b0;
        end else begin
            ram_ce  <= 1'b0;
            ram_rst <= 1'b0;
            done    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (clear || start) begin
                        // clear wins when both arrive together
                        state_q <= clear ? StClear : StFill;
                        addr_q  <= base_mod[AW-1:0];
                        len_q   <= len_eff;
                        cnt_q   <= '0;
                        words   <= '0;
                    end
                end
                StFill: begin
                    if (s_valid) begin
                        ram_ce   <= 1'b1;
                        ram_addr <= addr_q;
                        ram_din  <= s_data;
                        wr_ptr   <= addr_q;
                        words    <= cnt_inc;
                        addr_q   <= addr_inc;
                        cnt_q    <= cnt_inc;
                        if (s_last || (cnt_inc == len_q)) begin
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                StClear: begin
                    ram_ce   <= 1'b1;
                    ram_rst  <= 1'b1;
                    ram_addr <= addr_q;
                    addr_q   <= addr_inc;
                    cnt_q    <= cnt_inc;
                    if (cnt_inc == len_q) begin
                        done    <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sdpram_stream_writer.sv
// Randomised bench for sdpram_stream_writer. A behavioural RAM on the DUT's port-A
// outputs stands in for the real array; expected strobes and memory contents come from
// plain modular arithmetic over (base, beat index, effective length).
module tb_sdpram_stream_writer;

    localparam int unsigned DP = 20;
    localparam int unsigned DW = 8;
    localparam int unsigned AW = $clog2(DP);

    logic          CLKA = 1'b0;
    logic          rstb = 1'b1;
    logic          start = 1'b0;
    logic          clear = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic          ram_ce;
    logic          ram_rst;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   words;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;
    int mdl_wr_ptr = 0;
    logic [DW-1:0] ram     [DP];
    logic [DW-1:0] exp_mem [DP];

    sdpram_stream_writer #(.DP(DP), .DW(DW)) dut (
        .CLKA      (CLKA),
        .rstb      (rstb),
        .start     (start),
        .clear     (clear),
        .base_addr (base_addr),
        .length    (length),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .ram_ce    (ram_ce),
        .ram_rst   (ram_rst),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .wr_ptr    (wr_ptr),
        .words     (words),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLKA = ~CLKA;

    // Behavioural RAM port A: rsta forces zero.
    always @(posedge CLKA) begin
        if (ram_ce) ram[ram_addr] <= ram_rst ? '0 : ram_din;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int eff_len(input int len);
        return ((len == 0) || (len > int'(DP))) ? int'(DP) : len;
    endfunction

    // Checks the cycle after a (possible) accept: strobe contents and progress counters.
    task automatic check_strobe(input bit pv, input int pa, input logic [DW-1:0] pdat,
                                input bit pd, input int i);
        check_eq("ce", ram_ce, pv);
        if (pv) begin
            check_eq("rst", ram_rst, 0);
            check_eq("addr", ram_addr, pa);
            check_eq("din", ram_din, pdat);
        end
        check_eq("done", done, pv && pd);
        check_eq("words", words, i);
        check_eq("wr_ptr", wr_ptr, mdl_wr_ptr);
    endtask

    // One frame fill. last_at: 1-based beat carrying s_last (0 = none). gap: % of idle
    // cycles. pulse=0 means start was already sampled by the previous call (chained).
    task automatic run_frame(input int base, input int len, input int last_at, input int gap,
                             input bit pulse, input bit nxt, input int nbase, input int nlen);
        int n, bm, i, cyc, pa;
        bit v, pv, pd;
        logic [DW-1:0] dat, pdat;
        bm = base % int'(DP);
        n  = eff_len(len);
        if (last_at != 0 && last_at < n) n = last_at;
        if (pulse) begin
            base_addr = AW'(base);
            length    = (AW+1)'(len);
            start     = 1'b1;
            @(posedge CLKA); #1;
        end
        start = 1'b0;
        i = 0; cyc = 0; pv = 0; pd = 0; pa = 0; pdat = '0;
        while (i < n && cyc < 4 * int'(DP) + 50) begin
            v = ($urandom_range(99) >= gap);
            dat = DW'($urandom);
            s_valid = v;
            s_data  = dat;
            s_last  = v && (i + 1 == last_at);
            @(negedge CLKA);
            check_eq("fill_ready", s_ready, 1);
            check_strobe(pv, pa, pdat, pd, i);
            @(posedge CLKA); #1;
            pv = v;
            if (v) begin
                pa = (bm + i) % int'(DP);
                pdat = dat;
                pd = (i + 1 == n);
                exp_mem[pa] = dat;
                mdl_wr_ptr = pa;
                i++;
            end
            cyc++;
        end
        check_eq("fill_beats", i, n);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (nxt) begin
            base_addr = AW'(nbase);
            length    = (AW+1)'(nlen);
            start     = 1'b1;
        end
        @(negedge CLKA);
        check_strobe(pv, pa, pdat, pd, i);
        check_eq("end_busy", busy, 0);
        check_eq("end_ready", s_ready, 0);
        if (nxt) begin
            @(posedge CLKA); #1;
        end
    endtask

    // Zero sweep. with_start raises start alongside clear; poke_start pulses start mid-sweep.
    task automatic run_clear(input int base, input int len, input bit with_start,
                             input bit poke_start);
        int n, bm, a;
        bm = base % int'(DP);
        n  = eff_len(len);
        base_addr = AW'(base);
        length    = (AW+1)'(len);
        clear     = 1'b1;
        start     = with_start;
        @(posedge CLKA); #1;
        clear = 1'b0;
        start = 1'b0;
        @(negedge CLKA);
        check_eq("clr_ready", s_ready, 0);
        check_eq("clr_busy", busy, 1);
        check_eq("clr_ce0", ram_ce, 0);
        check_eq("clr_words", words, 0);
        for (int k = 0; k < n; k++) begin
            if (poke_start && k == 1) begin
                base_addr = AW'($urandom);
                start = 1'b1;
            end
            @(posedge CLKA); #1;
            start = 1'b0;
            @(negedge CLKA);
            a = (bm + k) % int'(DP);
            check_eq("clr_ce", ram_ce, 1);
            check_eq("clr_rst", ram_rst, 1);
            check_eq("clr_addr", ram_addr, a);
            check_eq("clr_done", done, k == n - 1);
            check_eq("clr_sready", s_ready, 0);
            check_eq("clr_wr_ptr", wr_ptr, mdl_wr_ptr);
            exp_mem[a] = '0;
        end
        check_eq("clr_end_busy", busy, 0);
        @(posedge CLKA); #1;
        @(negedge CLKA);
        check_eq("clr_idle_busy", busy, 0);
        check_eq("clr_idle_ready", s_ready, 0);
        check_eq("clr_idle_ce", ram_ce, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < int'(DP); a++) begin
            ram[a]     = DW'(8'hA0 ^ a);
            exp_mem[a] = DW'(8'hA0 ^ a);
        end
        repeat (3) @(posedge CLKA);
        @(negedge CLKA);
        check_eq("rst_ce", ram_ce, 0);
        check_eq("rst_rst", ram_rst, 0);
        check_eq("rst_addr", ram_addr, 0);
        check_eq("rst_din", ram_din, 0);
        check_eq("rst_wr_ptr", wr_ptr, 0);
        check_eq("rst_words", words, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_ready", s_ready, 0);
        @(posedge CLKA); #1;
        rstb = 1'b0;

        run_frame(0, 4, 0, 0, 1, 0, 0, 0);
        run_frame(int'(DP) - 2, 4, 0, 0, 1, 0, 0, 0);
        run_frame(5, 8, 3, 0, 1, 0, 0, 0);

        run_clear(10, 5, 0, 0);
        @(posedge CLKA); #1;
        for (int a = 9; a <= 15; a++) check_eq("clr_mem", ram[a], exp_mem[a]);

        run_frame(3, 16, 0, 50, 1, 0, 0, 0);
        run_frame(7, 0, 0, 30, 1, 0, 0, 0);
        // Oversized length, then back-to-back start in the done cycle with base >= DP.
        run_frame(12, 25, 0, 20, 1, 1, 25, 3);
        run_frame(25, 3, 0, 0, 0, 0, 0, 0);

        // Reset after two beats of a len=6 frame.
        base_addr = AW'(2);
        length    = (AW+1)'(6);
        start     = 1'b1;
        @(posedge CLKA); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h11;
        @(posedge CLKA); #1;
        s_data  = 8'h22;
        @(posedge CLKA); #1;
        exp_mem[2] = 8'h11;
        exp_mem[3] = 8'h22;
        rstb   = 1'b1;
        s_data = 8'h33;
        @(posedge CLKA); #1;
        @(negedge CLKA);
        mdl_wr_ptr = 0;
        check_eq("mid_rst_ce", ram_ce, 0);
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_ready", s_ready, 0);
        check_eq("mid_rst_done", done, 0);
        check_eq("mid_rst_words", words, 0);
        check_eq("mid_rst_wr_ptr", wr_ptr, 0);
        rstb    = 1'b0;
        s_valid = 1'b0;
        @(posedge CLKA); #1;

        run_clear(15, 3, 0, 1);
        run_clear(0, 2, 1, 0);

        for (int r = 0; r < 4; r++) begin
            run_frame(int'($urandom_range(31)), int'($urandom_range(30)),
                      int'($urandom_range(10)), int'($urandom_range(60)), 1, 0, 0, 0);
        end

        repeat (2) @(posedge CLKA);
        #1;
        for (int a = 0; a < int'(DP); a++) check_eq("mem", ram[a], exp_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
